// File: rtl/bids22_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : bids22_multi_if
// Brief    : Host control port and per-bidder bus of the bids22_multi auction.
// Revision : 1.0 - initial release
// ============================================================================
interface bids22_multi_if #(
   parameter int NUM_BIDDERS = 4,
   parameter int DATA_WIDTH  = 32
) ();
   localparam int c_iw = $clog2(NUM_BIDDERS);

   logic [3:0]                        C_op;
   logic [DATA_WIDTH-1:0]             C_data;
   logic [c_iw-1:0]                   C_idx;
   logic                              C_start;
   logic [NUM_BIDDERS-1:0]            bid;
   logic [NUM_BIDDERS-1:0]            retract;
   logic [NUM_BIDDERS*DATA_WIDTH-1:0] bid_amt;
   logic [NUM_BIDDERS-1:0]            ack;
   logic [2*NUM_BIDDERS-1:0]          bid_err;
   logic [NUM_BIDDERS*DATA_WIDTH-1:0] balance;
   logic [NUM_BIDDERS-1:0]            win;
   logic                              ready;
   logic [2:0]                        err;
   logic                              round_over;
   logic [DATA_WIDTH-1:0]             max_bid;
   logic [DATA_WIDTH-1:0]             price;

   modport master (
      output C_op, C_data, C_idx, C_start, bid, retract, bid_amt,
      input  ack, bid_err, balance, win, ready, err, round_over, max_bid, price
   );

   modport slave (
      input  C_op, C_data, C_idx, C_start, bid, retract, bid_amt,
      output ack, bid_err, balance, win, ready, err, round_over, max_bid, price
   );
endinterface
`default_nettype wire

// File: rtl/bids22_multi.sv
`default_nettype none
// ============================================================================
// Module   : bids22_multi
// Brief    : N-bidder auction controller, first/second-price, sequential scan.
// Revision : 1.0 - initial release
// ============================================================================
module bids22_multi #(
   parameter int NUM_BIDDERS = 4,
   parameter int DATA_WIDTH  = 32
) (
   input  wire logic     clk,
   input  wire logic     reset,
   bids22_multi_if.slave bus
);
   localparam int c_iw = $clog2(NUM_BIDDERS);
   localparam logic [c_iw:0]   c_num      = (c_iw+1)'(NUM_BIDDERS);
   localparam logic [c_iw-1:0] c_last_idx = c_iw'(NUM_BIDDERS-1);

   localparam logic [3:0] c_op_noop    = 4'd0;
   localparam logic [3:0] c_op_unlock  = 4'd1;
   localparam logic [3:0] c_op_lock    = 4'd2;
   localparam logic [3:0] c_op_load    = 4'd3;
   localparam logic [3:0] c_op_setmask = 4'd4;
   localparam logic [3:0] c_op_settmr  = 4'd5;
   localparam logic [3:0] c_op_setcost = 4'd6;
   localparam logic [3:0] c_op_setmode = 4'd7;

   localparam logic [2:0] c_err_none    = 3'd0;
   localparam logic [2:0] c_err_badkey  = 3'd1;
   localparam logic [2:0] c_err_already = 3'd2;
   localparam logic [2:0] c_err_cstart  = 3'd3;
   localparam logic [2:0] c_err_invalid = 3'd4;

   localparam logic [1:0] c_berr_funds   = 2'd1;
   localparam logic [1:0] c_berr_invalid = 2'd2;
   localparam logic [1:0] c_berr_dup     = 2'd3;

   typedef enum logic [2:0] {
      ST_UNLOCKED = 3'd0,
      ST_LOCKED   = 3'd1,
      ST_COOLDOWN = 3'd2,
      ST_ROUND    = 3'd3,
      ST_SCAN     = 3'd4,
      ST_SETTLE   = 3'd5
   } state_t;

   state_t r_state, w_next;

   logic [DATA_WIDTH-1:0]  r_balance [NUM_BIDDERS];
   logic [DATA_WIDTH-1:0]  r_last    [NUM_BIDDERS];
   logic [DATA_WIDTH-1:0]  w_amt     [NUM_BIDDERS];
   logic [NUM_BIDDERS-1:0] r_mask;
   logic [DATA_WIDTH-1:0]  r_timer, r_key, r_bidcost, r_cool;
   logic                   r_mode;
   logic [c_iw-1:0]        r_scan_idx, r_best_idx;
   logic [DATA_WIDTH-1:0]  r_best, r_second;

   logic [NUM_BIDDERS-1:0]   w_ack;
   logic [2*NUM_BIDDERS-1:0] w_bid_err;
   logic [NUM_BIDDERS-1:0]   w_win;
   logic [DATA_WIDTH-1:0]    w_price, w_max, w_scan_val;
   logic [2:0]               w_err;
   logic                     w_ready, w_round_over, w_idx_ok;

   assign w_idx_ok   = ({1'b0, bus.C_idx} < c_num);
   assign w_scan_val = r_last[r_scan_idx];

   generate
      for (genvar gi = 0; gi < NUM_BIDDERS; gi++) begin : g_lanes
         assign w_amt[gi]                                 = bus.bid_amt[gi*DATA_WIDTH +: DATA_WIDTH];
         assign bus.balance[gi*DATA_WIDTH +: DATA_WIDTH]  = r_balance[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_UNLOCKED;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_err        = c_err_none;
      w_ready      = (r_state != ST_SCAN) && (r_state != ST_SETTLE);
      w_round_over = (r_state == ST_SETTLE);
      w_price      = (r_best == '0) ? '0 : (r_mode ? r_second : r_best);
      for (int i = 0; i < NUM_BIDDERS; i++)
         w_win[i] = (r_state == ST_SETTLE) && (r_best != '0) && (r_best_idx == c_iw'(i));
      if (r_state != ST_SETTLE) w_price = '0;
      case (r_state)
         ST_UNLOCKED: begin
            if (bus.C_start) w_err = c_err_cstart;
            else begin
               case (bus.C_op)
                  c_op_noop, c_op_setmask, c_op_settmr,
                  c_op_setcost, c_op_setmode: ;
                  c_op_unlock: w_err = c_err_already;
                  c_op_lock:   w_next = ST_LOCKED;
                  c_op_load:   if (!w_idx_ok) w_err = c_err_invalid;
                  default:     w_err = c_err_invalid;
               endcase
            end
         end
         ST_LOCKED: begin
            if (bus.C_start) w_next = ST_ROUND;
            else if (bus.C_op == c_op_unlock)
               w_next = (bus.C_data == r_key) ? ST_UNLOCKED : ST_COOLDOWN;
            else if (bus.C_op != c_op_noop) w_err = c_err_invalid;
         end
         ST_COOLDOWN: begin
            w_err = c_err_badkey;
            if (r_cool == '0) w_next = ST_LOCKED;
         end
         ST_ROUND:  if (!bus.C_start) w_next = ST_SCAN;
         ST_SCAN:   if (r_scan_idx == c_last_idx) w_next = ST_SETTLE;
         ST_SETTLE: w_next = ST_LOCKED;
         default:   w_next = ST_UNLOCKED;
      endcase
   end

   // Lower-index acceptances are resolved first so same-cycle duplicates favour them.
   always_comb begin
      logic [NUM_BIDDERS-1:0]   v_ack;
      logic [2*NUM_BIDDERS-1:0] v_err;
      logic                     v_dup;
      v_ack = '0;
      v_err = '0;
      v_dup = 1'b0;
      for (int i = 0; i < NUM_BIDDERS; i++) begin
         v_dup = 1'b0;
         for (int j = 0; j < NUM_BIDDERS; j++) begin
            if (j != i && r_last[j] != '0 && r_last[j] == w_amt[i]) v_dup = 1'b1;
            if (j < i && v_ack[j] && w_amt[j] == w_amt[i])          v_dup = 1'b1;
         end
         if (bus.bid[i]) begin
            if (r_state != ST_ROUND || !r_mask[i])
               v_err[2*i +: 2] = c_berr_invalid;
            else if (({1'b0, w_amt[i]} + {1'b0, r_bidcost}) > {1'b0, r_balance[i]})
               v_err[2*i +: 2] = c_berr_funds;
            else if (v_dup)
               v_err[2*i +: 2] = c_berr_dup;
            else
               v_ack[i] = 1'b1;
         end
      end
      w_ack     = v_ack;
      w_bid_err = v_err;
   end

   always_comb begin
      w_max = '0;
      for (int i = 0; i < NUM_BIDDERS; i++)
         if (r_last[i] > w_max) w_max = r_last[i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_BIDDERS; i++) begin
            r_balance[i] <= '0;
            r_last[i]    <= '0;
         end
         r_mask     <= '1;
         r_timer    <= DATA_WIDTH'(15);
         r_key      <= '0;
         r_bidcost  <= DATA_WIDTH'(1);
         r_mode     <= 1'b0;
         r_cool     <= '0;
         r_scan_idx <= '0;
         r_best_idx <= '0;
         r_best     <= '0;
         r_second   <= '0;
      end else begin
         case (r_state)
            ST_UNLOCKED: begin
               if (!bus.C_start) begin
                  case (bus.C_op)
                     c_op_lock:    r_key <= bus.C_data;
                     c_op_load:    if (w_idx_ok) r_balance[bus.C_idx] <= bus.C_data;
                     c_op_setmask: r_mask <= bus.C_data[NUM_BIDDERS-1:0];
                     c_op_settmr:  r_timer <= bus.C_data;
                     c_op_setcost: r_bidcost <= bus.C_data;
                     c_op_setmode: r_mode <= bus.C_data[0];
                     default: ;
                  endcase
               end
            end
            ST_LOCKED: begin
               if (!bus.C_start && bus.C_op == c_op_unlock && bus.C_data != r_key)
                  r_cool <= r_timer;
            end
            ST_COOLDOWN: begin
               if (r_cool != '0) r_cool <= r_cool - DATA_WIDTH'(1);
            end
            ST_ROUND: begin
               for (int i = 0; i < NUM_BIDDERS; i++) begin
                  if (w_ack[i]) begin
                     r_balance[i] <= r_balance[i] - r_bidcost;
                     r_last[i]    <= w_amt[i];
                  end else if (bus.retract[i] && !bus.bid[i]) begin
                     r_last[i] <= '0;
                  end
               end
               if (!bus.C_start) begin
                  r_scan_idx <= '0;
                  r_best_idx <= '0;
                  r_best     <= '0;
                  r_second   <= '0;
               end
            end
            ST_SCAN: begin
               // Strictly-greater keeps the earliest index on a tie.
               if (w_scan_val > r_best) begin
                  r_second   <= r_best;
                  r_best     <= w_scan_val;
                  r_best_idx <= r_scan_idx;
               end else if (w_scan_val > r_second) begin
                  r_second <= w_scan_val;
               end
               r_scan_idx <= r_scan_idx + c_iw'(1);
            end
            ST_SETTLE: begin
               if (r_best != '0) r_balance[r_best_idx] <= r_balance[r_best_idx] - w_price;
               for (int i = 0; i < NUM_BIDDERS; i++) r_last[i] <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.ack        = w_ack;
   assign bus.bid_err    = w_bid_err;
   assign bus.win        = w_win;
   assign bus.ready      = w_ready;
   assign bus.err        = w_err;
   assign bus.round_over = w_round_over;
   assign bus.max_bid    = w_max;
   assign bus.price      = w_price;
endmodule
`default_nettype wire

// File: tb/tb_bids22_multi.sv
`default_nettype none
// Testbench for bids22_multi: directed scenarios plus randomized rounds
// checked against an array-based auction model.
module tb_bids22_multi;
   localparam int N  = 4;
   localparam int DW = 32;

   localparam logic [3:0] OP_NOOP = 4'd0, OP_UNLOCK = 4'd1, OP_LOCK = 4'd2, OP_LOAD = 4'd3;
   localparam logic [3:0] OP_SETMASK = 4'd4, OP_SETTIMER = 4'd5, OP_SETCOST = 4'd6, OP_SETMODE = 4'd7;
   localparam logic [DW-1:0] KEY = 32'h3C;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bids22_multi_if #(.NUM_BIDDERS(N), .DATA_WIDTH(DW)) bus ();
   bids22_multi #(.NUM_BIDDERS(N), .DATA_WIDTH(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] m_bal  [N];
   logic [DW-1:0] m_last [N];
   logic [N-1:0]  m_mask;
   logic [DW-1:0] m_cost;
   logic          m_mode;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_bal[i]  = '0;
         m_last[i] = '0;
      end
      m_mask = '1;
      m_cost = 32'd1;
      m_mode = 1'b0;
   endtask

   task automatic host_op(input logic [3:0] op, input logic [DW-1:0] data, input logic [1:0] idx,
                          input int exp_err);
      bus.C_op = op; bus.C_data = data; bus.C_idx = idx;
      #1;
      if (exp_err >= 0) check_value($sformatf("err_op%0d", op), bus.err, exp_err);
      tick();
      if (exp_err == 0) begin
         case (op)
            OP_LOAD:    m_bal[idx] = data;
            OP_SETMASK: m_mask = data[N-1:0];
            OP_SETCOST: m_cost = data;
            OP_SETMODE: m_mode = data[0];
            default: ;
         endcase
      end
      bus.C_op = OP_NOOP; bus.C_data = '0; bus.C_idx = '0;
   endtask

   task automatic start_round();
      host_op(OP_LOCK, KEY, 2'd0, 0);
      bus.C_start = 1'b1;
      tick();
   endtask

   task automatic bid_cycle(input logic in_round, input logic [N-1:0] b, input logic [N-1:0] r,
                            input logic [N*DW-1:0] amts,
                            output logic [N-1:0] got_ack, output logic [2*N-1:0] got_err);
      logic [DW-1:0]  a [N];
      logic [N-1:0]   e_ack;
      logic [2*N-1:0] e_err;
      logic           dup;
      for (int i = 0; i < N; i++) a[i] = amts[i*DW +: DW];
      bus.bid = b; bus.retract = r; bus.bid_amt = amts;
      #1;
      e_ack = '0;
      e_err = '0;
      for (int i = 0; i < N; i++) begin
         if (b[i]) begin
            if (!in_round || !m_mask[i]) e_err[2*i +: 2] = 2'd2;
            else if ({32'b0, a[i]} + {32'b0, m_cost} > {32'b0, m_bal[i]}) e_err[2*i +: 2] = 2'd1;
            else begin
               dup = 1'b0;
               for (int j = 0; j < N; j++) begin
                  if (j != i && m_last[j] != 0 && m_last[j] == a[i]) dup = 1'b1;
                  if (j < i && e_ack[j] && a[j] == a[i]) dup = 1'b1;
               end
               if (dup) e_err[2*i +: 2] = 2'd3;
               else     e_ack[i] = 1'b1;
            end
         end
      end
      got_ack = bus.ack;
      got_err = bus.bid_err;
      check_value("ack", got_ack, e_ack);
      check_value("bid_err", got_err, e_err);
      tick();
      if (in_round) begin
         for (int i = 0; i < N; i++) begin
            if (e_ack[i]) begin
               m_bal[i]  = m_bal[i] - m_cost;
               m_last[i] = a[i];
            end else if (r[i] && !b[i]) m_last[i] = '0;
         end
      end
      bus.bid = '0; bus.retract = '0; bus.bid_amt = '0;
   endtask

   task automatic finish_round(output logic [N-1:0] got_win, output logic [DW-1:0] got_price);
      logic [DW-1:0] best, second, price;
      logic [N-1:0]  ewin;
      int            bi;
      bus.C_start = 1'b0;
      tick();
      best = '0; bi = 0;
      for (int i = 0; i < N; i++)
         if (m_last[i] > best) begin best = m_last[i]; bi = i; end
      second = '0;
      for (int i = 0; i < N; i++)
         if (i != bi && m_last[i] > second) second = m_last[i];
      for (int k = 0; k < N; k++) begin
         check_value("scan_ready", bus.ready, 1'b0);
         check_value("scan_round_over", bus.round_over, 1'b0);
         check_value("scan_win", bus.win, '0);
         check_value("scan_max_bid", bus.max_bid, best);
         tick();
      end
      price = (best == 0) ? '0 : (m_mode ? second : best);
      ewin  = (best == 0) ? '0 : (N'(1) << bi);
      got_win   = bus.win;
      got_price = bus.price;
      check_value("settle_win", got_win, ewin);
      check_value("settle_price", got_price, price);
      check_value("settle_round_over", bus.round_over, 1'b1);
      check_value("settle_ready", bus.ready, 1'b0);
      tick();
      if (best != 0) m_bal[bi] = m_bal[bi] - price;
      for (int i = 0; i < N; i++) m_last[i] = '0;
      check_value("post_ready", bus.ready, 1'b1);
      check_value("post_max_bid", bus.max_bid, '0);
      for (int i = 0; i < N; i++)
         check_value($sformatf("post_bal%0d", i), bus.balance[i*DW +: DW], m_bal[i]);
   endtask

   task automatic cooldown_len(input logic [DW-1:0] bad, input int exp_len);
      int cnt;
      host_op(OP_UNLOCK, bad, 2'd0, -1);
      #1;
      cnt = 0;
      while (bus.err == 3'd1 && cnt < 40) begin
         cnt++;
         tick();
      end
      check_value("cooldown_len", cnt, exp_len);
   endtask

   initial begin
      logic [N-1:0]    ga, gw;
      logic [2*N-1:0]  ge;
      logic [DW-1:0]   gp;
      logic [N*DW-1:0] amts;
      logic [DW-1:0]   e_bal [N];
      logic [N-1:0]    rb, rr;

      reset = 1'b1;
      bus.C_op = OP_NOOP; bus.C_data = '0; bus.C_idx = '0; bus.C_start = 1'b0;
      bus.bid = '0; bus.retract = '0; bus.bid_amt = '0;
      model_reset();
      repeat (3) tick();
      reset = 1'b0;
      #1;
      check_value("rst_ready", bus.ready, 1'b1);
      check_value("rst_err", bus.err, 3'd0);
      check_value("rst_win", bus.win, '0);
      check_value("rst_price", bus.price, '0);
      check_value("rst_max_bid", bus.max_bid, '0);
      check_value("rst_round_over", bus.round_over, 1'b0);
      check_value("rst_ack", bus.ack, '0);
      for (int i = 0; i < N; i++) check_value($sformatf("rst_bal%0d", i), bus.balance[i*DW +: DW], 0);

      // Cooldown with the default timer, then with timer 0.
      host_op(OP_LOCK, 32'hA5, 2'd0, 0);
      cooldown_len(32'h11, 16);
      host_op(OP_UNLOCK, 32'hA5, 2'd0, 0);
      host_op(OP_UNLOCK, 32'h0, 2'd0, 2);
      host_op(OP_SETTIMER, 32'd0, 2'd0, 0);
      host_op(OP_LOCK, 32'h5, 2'd0, 0);
      host_op(OP_LOAD, 32'd7, 2'd0, 4);
      cooldown_len(32'h6, 1);
      host_op(OP_UNLOCK, 32'h5, 2'd0, 0);
      host_op(4'd9, 32'd0, 2'd0, 4);
      bus.C_start = 1'b1;
      #1;
      check_value("cstart_unlocked", bus.err, 3'd3);
      tick();
      bus.C_start = 1'b0;

      // First-price round.
      for (int i = 0; i < N; i++) host_op(OP_LOAD, 32'd100, 2'(i), 0);
      host_op(OP_SETCOST, 32'd1, 2'd0, 0);
      start_round();
      bid_cycle(1'b1, 4'b0111, 4'b0000, {32'd0, 32'd20, 32'd30, 32'd10}, ga, ge);
      check_value("fp_ack", ga, 4'b0111);
      finish_round(gw, gp);
      check_value("fp_win", gw, 4'b0010);
      check_value("fp_price", gp, 32'd30);
      e_bal = '{32'd99, 32'd69, 32'd99, 32'd100};
      for (int i = 0; i < N; i++) check_value($sformatf("fp_bal%0d", i), bus.balance[i*DW +: DW], e_bal[i]);

      // Second-price round.
      host_op(OP_UNLOCK, KEY, 2'd0, 0);
      host_op(OP_SETMODE, 32'd1, 2'd0, 0);
      for (int i = 0; i < N; i++) host_op(OP_LOAD, 32'd100, 2'(i), 0);
      start_round();
      bid_cycle(1'b1, 4'b0111, 4'b0000, {32'd0, 32'd20, 32'd30, 32'd10}, ga, ge);
      finish_round(gw, gp);
      check_value("sp_win", gw, 4'b0010);
      check_value("sp_price", gp, 32'd20);
      check_value("sp_bal1", bus.balance[1*DW +: DW], 32'd79);

      // Same-cycle duplicate.
      host_op(OP_UNLOCK, KEY, 2'd0, 0);
      host_op(OP_SETMODE, 32'd0, 2'd0, 0);
      start_round();
      bid_cycle(1'b1, 4'b1010, 4'b0000, {32'd25, 32'd0, 32'd25, 32'd0}, ga, ge);
      check_value("dup_ack1", ga[1], 1'b1);
      check_value("dup_ack3", ga[3], 1'b0);
      check_value("dup_err3", ge[7:6], 2'd3);
      finish_round(gw, gp);

      // Mask and funds rejections.
      host_op(OP_UNLOCK, KEY, 2'd0, 0);
      host_op(OP_SETMASK, 32'hE, 2'd0, 0);
      host_op(OP_LOAD, 32'd10, 2'd2, 0);
      start_round();
      bid_cycle(1'b1, 4'b0101, 4'b0000, {32'd0, 32'd10, 32'd0, 32'd5}, ga, ge);
      check_value("mask_err0", ge[1:0], 2'd2);
      check_value("funds_err2", ge[5:4], 2'd1);
      finish_round(gw, gp);
      host_op(OP_UNLOCK, KEY, 2'd0, 0);
      host_op(OP_SETMASK, 32'hF, 2'd0, 0);
      bid_cycle(1'b0, 4'b1111, 4'b1111, {4{32'd3}}, ga, ge);
      check_value("outside_err", ge, 8'hAA);

      // Reset during SCAN aborts the round.
      start_round();
      bid_cycle(1'b1, 4'b0001, 4'b0000, {32'd0, 32'd0, 32'd0, 32'd40}, ga, ge);
      bus.C_start = 1'b0;
      tick();
      tick();
      check_value("abort_in_scan", bus.ready, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      check_value("abort_ready", bus.ready, 1'b1);
      check_value("abort_win", bus.win, '0);
      check_value("abort_max_bid", bus.max_bid, '0);
      for (int i = 0; i < N; i++) check_value($sformatf("abort_bal%0d", i), bus.balance[i*DW +: DW], 0);

      // Round with no bids.
      start_round();
      finish_round(gw, gp);
      check_value("empty_win", gw, '0);
      check_value("empty_price", gp, '0);
      host_op(OP_UNLOCK, KEY, 2'd0, 0);

      // Randomized rounds.
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < N; i++) host_op(OP_LOAD, $urandom_range(0, 60), 2'(i), 0);
         host_op(OP_SETMASK, ($urandom_range(0, 3) == 0) ? $urandom : 32'hF, 2'd0, 0);
         host_op(OP_SETCOST, $urandom_range(0, 3), 2'd0, 0);
         host_op(OP_SETMODE, $urandom, 2'd0, 0);
         start_round();
         repeat ($urandom_range(1, 6)) begin
            rb = N'($urandom);
            rr = N'($urandom);
            for (int i = 0; i < N; i++) amts[i*DW +: DW] = $urandom_range(0, 40);
            bid_cycle(1'b1, rb, rr, amts, ga, ge);
         end
         finish_round(gw, gp);
         host_op(OP_UNLOCK, KEY, 2'd0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: bench did not complete, expected completion before 400000");
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/bids22_multi.md
# bids22_multi

Parametrised successor of the three-bidder `bids22` auction controller. It supports `NUM_BIDDERS` bidders, runtime-selectable first-price or second-price (Vickrey) settlement, and same-cycle duplicate-bid arbitration. The winner is resolved by a sequential scan, one bidder per cycle, instead of a combinational max. It sits between the auction host (`C_*` control port) and the per-bidder ports; all bidder fields are flat packed vectors, with bidder i at slice i.

## Interface
- `NUM_BIDDERS`, 4: number of bidders, 2..16.
- `DATA_WIDTH`, 32: width of balances, bids, key, timer and charge.
- `clk` in 1: single clock; everything is sampled on its rising edge.
- `reset` in 1: synchronous, active-high.
- `C_op` in 4: opcode. NO_OP=0, UNLOCK=1, LOCK=2, LOAD=3, SETMASK=4, SETTIMER=5, SETBIDCHARGE=6, SETMODE=7; 8..15 are invalid.
- `C_data` in DATA_WIDTH: opcode operand.
- `C_idx` in $clog2(NUM_BIDDERS): bidder index used by LOAD.
- `C_start` in 1: round in progress while high.
- `bid`, `retract` in NUM_BIDDERS: per-bidder request strobes.
- `bid_amt` in NUM_BIDDERS*DATA_WIDTH: per-bidder bid amount.
- `ack` out NUM_BIDDERS: bid accepted this cycle (combinational).
- `bid_err` out NUM_BIDDERS*2: per-bidder error. 0 none, 1 INSUFFICIENTFUNDS, 2 INVALIDREQUEST, 3 DUPLICATE.
- `balance` out NUM_BIDDERS*DATA_WIDTH: registered balance per bidder.
- `win` out NUM_BIDDERS: one-hot winner, valid only on the SETTLE cycle.
- `ready` out 1: low during SCAN and SETTLE.
- `err` out 3: host error. 0 NOERROR, 1 BADKEY, 2 ALREADYUNLOCKED, 3 CSTARTWHENUNLOCKED, 4 INVALID_OP.
- `round_over` out 1: one-cycle pulse on SETTLE.
- `max_bid` out DATA_WIDTH: current highest live bid.
- `price` out DATA_WIDTH: amount charged to the winner, valid on SETTLE.

## Operation
- **Reset values:**
  - state UNLOCKED; all balances and last-bids 0.
  - mask all ones; timer_value 15; key 0; bidcost 1; mode 0 (first-price).
  - All outputs 0 except `ready`=1.
- **UNLOCKED:**
  - LOCK stores `C_data` as key and moves to LOCKED.
  - LOAD writes `C_data` to the balance of bidder `C_idx`. An index ≥ NUM_BIDDERS gives INVALID_OP with no write.
  - SETMASK, SETTIMER and SETBIDCHARGE write the low bits of `C_data` to mask, timer_value and bidcost respectively. SETMODE writes `C_data[0]` to mode.
  - UNLOCK gives ALREADYUNLOCKED. Any invalid opcode gives INVALID_OP.
  - `C_start`=1 gives CSTARTWHENUNLOCKED and ignores `C_op` that cycle.
- **LOCKED:**
  - `C_start`=1 moves to ROUNDSTARTED; this takes priority over `C_op`.
  - UNLOCK with `C_data`==key moves to UNLOCKED.
  - UNLOCK with a wrong key loads the cooldown counter with timer_value and moves to COOLDOWN.
  - Any other non-NO_OP opcode gives INVALID_OP.
- **COOLDOWN:**
  - `err`=BADKEY every cycle; all inputs ignored.
  - The counter decrements each cycle. When it reads 0 the next state is LOCKED, so a timer_value of 0 gives exactly 1 cooldown cycle.
- **ROUNDSTARTED:** for each i with `bid[i]`:
  - If mask[i]=0, reject with INVALIDREQUEST.
  - Else if bid_amt+bidcost > balance (computed at DATA_WIDTH+1 bits), reject with INSUFFICIENTFUNDS.
  - Else if bid_amt equals another bidder's nonzero last-bid, or equals the bid_amt of a lower-index bidder accepted in the same cycle, reject with DUPLICATE.
  - Otherwise `ack[i]`=1. On the next edge: balance -= bidcost, last-bid = bid_amt.
- **Retract:**
  - `retract[i]` without `bid[i]` clears last-bid[i]. The bidcost is not refunded.
  - A retract asserted together with bid is ignored.
- **Requests outside ROUNDSTARTED:** `bid[i]` gives INVALIDREQUEST; `retract[i]` is ignored.
- **max_bid:** the combinational max of the last-bids, held through SCAN.
- **End of round:** `C_start` sampled low in ROUNDSTARTED moves to SCAN.
- **SCAN:** runs exactly NUM_BIDDERS cycles. Index k visits bidder k in order, updating the registered best value, best index and second value. A strictly-greater comparison means the lowest index wins a tie.
- **SETTLE:** one cycle.
  - If the best value is nonzero: `win[best]`=1 and balance[best] -= price.
  - price = best value in mode 0; the second value in mode 1 (0 if only one live bid).
  - With no live bid: `win`=0 and `price`=0.
  - `round_over`=1. All last-bids are cleared at the closing edge. Next state is LOCKED.
- **Reset mid-round:** aborts the round with no charge; all registers return to their reset values.

## Timing
- `ack` and `bid_err` respond in the same cycle as `bid`. The balance update is visible one cycle later.
- `C_start` sampled low at edge t: SCAN covers cycles t+1..t+NUM_BIDDERS, SETTLE is cycle t+NUM_BIDDERS+1, and the state is LOCKED at t+NUM_BIDDERS+2.
- `ready`=0 exactly during SCAN and SETTLE.
- `err` is combinational and held for 1 cycle per offending input. In COOLDOWN it is held continuously.
- Balance arithmetic cannot underflow, because acceptance guarantees balance ≥ bid+bidcost and price ≤ the winner's last-bid.

## Test plan
- **Cooldown timing:** reset, LOCK key=0xA5, UNLOCK 0x11 → COOLDOWN with `err`=1 for 16 cycles (timer 15), then LOCKED. Next, UNLOCK 0xA5 → UNLOCKED.
- **First-price round (N=4):** LOAD 100 into every bidder, bidcost 1, lock, start.
  - Bidders 0/1/2 bid 10/30/20 → `ack`=0111.
  - End round → SCAN of 4 cycles, then SETTLE with `win`=0010, `price`=30.
  - Final balances 99/69/99/100.
- **Second-price round:** same stimulus with SETMODE 1 → `win`=0010, `price`=20, balance[1]=79.
- **Duplicate arbitration:** bidders 1 and 3 bid 25 in the same cycle → `ack`[1]=1; bidder 3 gets `ack`[3]=0 with `bid_err`=3.
- **Rejections:**
  - With mask=1110, bidder 0 bids → `bid_err`=2.
  - Bidder with balance 10, bidcost 1, bids 10 → `bid_err`=1.
- **Abort and empty round:** assert `reset` during SCAN → all balances 0, `ready`=1, no `win`. Separately, a round with no bids → SETTLE with `win`=0, `price`=0, `round_over`=1.
